// File: rtl/cast_rr_scheduler.sv
// Round-robin scheduler sharing one saturating unsigned fixed-point cast stage across N_CH channels.
// Optional saturation flag/counter outputs enabled by defining CAST_SAT_COUNT_EN.
module cast_rr_scheduler #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DIN_WIDTH  = 8,
    parameter int unsigned DIN_POINT  = 4,
    parameter int unsigned DOUT_WIDTH = 16,
    parameter int unsigned DOUT_POINT = 11,
    parameter int unsigned CH_W       = $clog2(N_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH*DIN_WIDTH-1:0]    din,
    input  logic [N_CH-1:0]              din_valid,
    output logic [N_CH-1:0]              din_ready,
    output logic [DOUT_WIDTH-1:0]        dout,
    output logic [CH_W-1:0]              dout_ch,
    output logic                         dout_valid,
    input  logic                         dout_ready
`ifdef CAST_SAT_COUNT_EN
    ,
    output logic                         sat_flag,
    output logic [15:0]                  sat_count
`endif
);

    localparam int unsigned DOUT_INT = DOUT_WIDTH - DOUT_POINT;
    // Input bits at or above this index do not fit the output integer field.
    localparam int unsigned SAT_BIT  = DIN_POINT + DOUT_INT;
    localparam int unsigned CNT_W    = 16;

    logic [DIN_WIDTH-1:0]  hold_q [N_CH];
    logic [DIN_WIDTH-1:0]  hold_d [N_CH];
    logic [N_CH-1:0]       full_q, full_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic [CH_W-1:0]       dout_ch_q, dout_ch_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]      sat_count_q, sat_count_d;

    logic                  advance_c;
    logic                  gnt_found_c;
    logic [CH_W-1:0]       gnt_idx_c;
    logic [DOUT_WIDTH:0]   cast_res_c;

    // Bit-aligned recast: MSB of result is the saturation indicator.
    function automatic logic [DOUT_WIDTH:0] cast_word(input logic [DIN_WIDTH-1:0] x);
        logic [DOUT_WIDTH-1:0] y;
        logic                  sat;
        y   = '0;
        sat = 1'b0;
        for (int o = 0; o < int'(DOUT_WIDTH); o++) begin
            int src;
            src = o - int'(DOUT_POINT) + int'(DIN_POINT);
            if (src >= 0 && src < int'(DIN_WIDTH)) y[o] = x[src];
        end
        for (int i = int'(SAT_BIT); i < int'(DIN_WIDTH); i++) sat = sat | x[i];
        if (sat) y = '1;
        return {sat, y};
    endfunction

    // Round-robin search starting at the pointer, ascending modulo N_CH.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            int c;
            c = int'(ptr_q) + k;
            if (c >= int'(N_CH)) c = c - int'(N_CH);
            if (!gnt_found_c && full_q[c]) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = CH_W'(c);
            end
        end
    end

    assign advance_c  = ~dout_valid_q | dout_ready;
    assign cast_res_c = cast_word(hold_q[gnt_idx_c]);

    always_comb begin
        hold_d       = hold_q;
        full_d       = full_q;
        ptr_d        = ptr_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        sat_flag_d   = sat_flag_q;
        sat_count_d  = sat_count_q;

        // Holders load only when empty, so a load never collides with a grant.
        for (int i = 0; i < int'(N_CH); i++) begin
            if (din_valid[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                hold_d[i] = din[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end

        if (advance_c) begin
            if (gnt_found_c) begin
                full_d[gnt_idx_c] = 1'b0;
                dout_d            = cast_res_c[DOUT_WIDTH-1:0];
                sat_flag_d        = cast_res_c[DOUT_WIDTH];
                dout_ch_d         = gnt_idx_c;
                dout_valid_d      = 1'b1;
                ptr_d             = (int'(gnt_idx_c) == int'(N_CH) - 1) ? '0 : gnt_idx_c + CH_W'(1);
            end else begin
                dout_valid_d = 1'b0;
            end
        end

        if (dout_valid_q && dout_ready && sat_flag_q && (sat_count_q != '1))
            sat_count_d = sat_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) hold_q[i] <= '0;
            full_q       <= '0;
            ptr_q        <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            hold_q       <= hold_d;
            full_q       <= full_d;
            ptr_q        <= ptr_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            sat_flag_q   <= sat_flag_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign din_ready  = ~full_q;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

`ifdef CAST_SAT_COUNT_EN
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;
`else
    logic unused_sat_c;
    assign unused_sat_c = ^{sat_flag_q, sat_count_q};
`endif

endmodule

// File: tb/tb_cast_rr_scheduler.sv
// Scoreboard bench for cast_rr_scheduler: default 4-channel instance plus a 16/8 -> 8/4 narrowing instance.
module tb_cast_rr_scheduler;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned OW   = 16;
    localparam int unsigned CH_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH*DW-1:0]   din;
    logic [N_CH-1:0]      din_valid;
    logic [N_CH-1:0]      din_ready;
    logic [OW-1:0]        dout;
    logic [CH_W-1:0]      dout_ch;
    logic                 dout_valid;
    logic                 dout_ready;

    logic [31:0]          p_din;
    logic [1:0]           p_din_valid;
    logic [1:0]           p_din_ready;
    logic [7:0]           p_dout;
    logic                 p_dout_ch;
    logic                 p_dout_valid;
    logic                 p_dout_ready;

`ifdef CAST_SAT_COUNT_EN
    logic                 sat_flag;
    logic [15:0]          sat_count;
    logic                 p_sat_flag;
    logic [15:0]          p_sat_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   obs_ch[$];

    always #5 clk = ~clk;

    cast_rr_scheduler u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef CAST_SAT_COUNT_EN
        ,
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
`endif
    );

    cast_rr_scheduler #(
        .N_CH(2), .DIN_WIDTH(16), .DIN_POINT(8), .DOUT_WIDTH(8), .DOUT_POINT(4)
    ) u_dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (p_din),
        .din_valid  (p_din_valid),
        .din_ready  (p_din_ready),
        .dout       (p_dout),
        .dout_ch    (p_dout_ch),
        .dout_valid (p_dout_valid),
        .dout_ready (p_dout_ready)
`ifdef CAST_SAT_COUNT_EN
        ,
        .sat_flag   (p_sat_flag),
        .sat_count  (p_sat_count)
`endif
    );

    // 8/4 -> 16/11 is a left shift by 7; the result can never overflow 16 bits.
    function automatic logic [15:0] model_a(input logic [7:0] x);
        logic [15:0] t;
        t = {8'h00, x};
        return t << 7;
    endfunction

    // 16/8 -> 8/4 is a right shift by 4, clamped to 0xFF.
    function automatic logic [7:0] model_b(input logic [15:0] x);
        logic [15:0] t;
        t = x >> 4;
        return (t > 16'h00FF) ? 8'hFF : t[7:0];
    endfunction

    // Push accepted inputs, pop and compare delivered outputs (per-channel order).
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (din_valid[i] && din_ready[i])
                    sb.push_back('{ch: 4'(i), data: model_a(din[i*DW +: DW])});
            end
            if (dout_valid && dout_ready) begin
                int idx;
                idx = -1;
                obs_ch.push_back(int'(dout_ch));
                foreach (sb[k]) if (idx < 0 && sb[k].ch == 4'(dout_ch)) idx = k;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got ch=%0d data=%h, expected no output", dout_ch, dout);
                end else begin
                    if (dout !== sb[idx].data) begin
                        errors++;
                        $display("FAIL scoreboard_data ch%0d: got %h, expected %h", dout_ch, dout, sb[idx].data);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        din_valid   = '0;
        p_din_valid = '0;
        dout_ready  = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        sb.delete();
        obs_ch.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !dout_valid) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        din         = '0;
        din_valid   = '0;
        dout_ready  = 1'b1;
        p_din       = '0;
        p_din_valid = '0;
        p_dout_ready = 1'b1;
        #3;
        checks++;
        if (din_ready !== 4'hF) begin errors++; $display("FAIL reset_din_ready: got %b, expected 1111", din_ready); end
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b, expected 0", dout_valid); end
        checks++;
        if (dout !== 16'h0000 || dout_ch !== 2'd0) begin
            errors++; $display("FAIL reset_dout: got dout=%h ch=%0d, expected 0000/0", dout, dout_ch);
        end
        checks++;
        if (p_din_ready !== 2'b11 || p_dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_param_inst: got ready=%b valid=%b, expected 11/0", p_din_ready, p_dout_valid);
        end
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (sat_flag !== 1'b0 || sat_count !== 16'h0) begin
            errors++; $display("FAIL reset_sat: got flag=%b count=%h, expected 0/0000", sat_flag, sat_count);
        end
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        obs_ch.delete();
        din[7:0]  = 8'h9C;
        din_valid = 4'b0001;
        step();
        din_valid = '0;
        checks++;
        if (dout_valid !== 1'b0 || din_ready[0] !== 1'b0) begin
            errors++; $display("FAIL single_accept: got valid=%b ready0=%b, expected 0/0", dout_valid, din_ready[0]);
        end
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 16'h4E00 || dout_ch !== 2'd0) begin
            errors++; $display("FAIL single_out: got valid=%b dout=%h ch=%0d, expected 1/4e00/0", dout_valid, dout, dout_ch);
        end
        step();
        checks++;
        if (dout_valid !== 1'b0 || dout !== 16'h4E00) begin
            errors++; $display("FAIL single_one_cycle: got valid=%b dout=%h, expected 0/4e00", dout_valid, dout);
        end
        checks++;
        if (obs_ch.size() != 1 || sb.size() != 0) begin
            errors++; $display("FAIL single_count: got %0d outputs, %0d pending, expected 1/0", obs_ch.size(), sb.size());
        end
    endtask

    task automatic test_round_robin();
        int rcnt;
        rcnt = 0;
        do_reset();
        din       = 32'hFF00_9C01;
        din_valid = '1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c >= 1 && c <= 16) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_ch !== 2'((c - 1) % 4)) begin
                    errors++;
                    $display("FAIL rr_seq cycle %0d: got valid=%b ch=%0d, expected 1/%0d", c, dout_valid, dout_ch, (c - 1) % 4);
                end
                if (din_ready[0]) rcnt++;
            end
            din = $urandom();
        end
        din_valid = '0;
        checks++;
        if (rcnt != 4) begin errors++; $display("FAIL rr_ready_rate: got %0d ready cycles, expected 4", rcnt); end
        drain(20);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        obs_ch.delete();
        dout_ready  = 1'b0;
        din[23:16]  = 8'h3A;
        din_valid   = 4'b0100;
        step();
        din_valid = '0;
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout !== model_a(8'h3A) || dout_ch !== 2'd2) begin
            errors++; $display("FAIL bp_first: got valid=%b dout=%h ch=%0d, expected 1/%h/2", dout_valid, dout, dout_ch, model_a(8'h3A));
        end
        din[23:16] = 8'hC7;
        din_valid  = 4'b0100;
        step();
        din_valid = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (dout_valid !== 1'b1 || dout !== model_a(8'h3A) || dout_ch !== 2'd2 || din_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b dout=%h ch=%0d ready2=%b, expected 1/%h/2/0",
                         c, dout_valid, dout, dout_ch, din_ready[2], model_a(8'h3A));
            end
        end
        dout_ready = 1'b1;
        drain(10);
        checks++;
        if (obs_ch.size() != 2 || sb.size() != 0) begin
            errors++; $display("FAIL bp_release: got %0d outputs, %0d pending, expected 2/0", obs_ch.size(), sb.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        din[31:24] = 8'h55;
        din_valid  = 4'b1000;
        step();
        din_valid = '0;
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout_ch !== 2'd3 || dout !== model_a(8'h55)) begin
            errors++; $display("FAIL wrap_ch3: got valid=%b ch=%0d dout=%h, expected 1/3/%h", dout_valid, dout_ch, dout, model_a(8'h55));
        end
        din[31:24] = 8'h66;
        din[15:8]  = 8'h77;
        din_valid  = 4'b1010;
        step();
        din_valid = '0;
        step();
        checks++;
        if (dout_ch !== 2'd1 || dout !== model_a(8'h77)) begin
            errors++; $display("FAIL wrap_ch1_first: got ch=%0d dout=%h, expected 1/%h", dout_ch, dout, model_a(8'h77));
        end
        step();
        checks++;
        if (dout_ch !== 2'd3 || dout !== model_a(8'h66)) begin
            errors++; $display("FAIL wrap_ch3_second: got ch=%0d dout=%h, expected 3/%h", dout_ch, dout, model_a(8'h66));
        end
        drain(10);
    endtask

    task automatic test_reset_mid();
        do_reset();
        din_valid = '1;
        for (int c = 0; c < 5; c++) begin
            step();
            din = $urandom();
        end
        checks++;
        if (dout_valid !== 1'b1 || din_ready === 4'hF) begin
            errors++; $display("FAIL rmid_pre: got valid=%b ready=%b, expected 1/not 1111", dout_valid, din_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 4'hF || dout !== 16'h0 || dout_ch !== 2'd0) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b ready=%b dout=%h ch=%0d, expected 0/1111/0000/0", dout_valid, din_ready, dout, dout_ch);
        end
        din_valid = '0;
        step();
        rst_n = 1'b1;
        sb.delete();
        obs_ch.delete();
        din       = $urandom();
        din_valid = '1;
        step();
        din_valid = '0;
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout_ch !== 2'd0) begin
            errors++; $display("FAIL rmid_first_grant: got valid=%b ch=%0d, expected 1/0", dout_valid, dout_ch);
        end
        drain(10);
        checks++;
        if (sb.size() != 0 || obs_ch.size() != 4) begin
            errors++; $display("FAIL rmid_drain: got %0d outputs, %0d pending, expected 4/0", obs_ch.size(), sb.size());
        end
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (sat_count !== 16'h0) begin errors++; $display("FAIL default_sat_count: got %h, expected 0000", sat_count); end
`endif
    endtask

    task automatic test_cast_params();
        p_dout_ready = 1'b1;
        p_din        = {16'h1080, 16'h0F80};
        p_din_valid  = 2'b11;
        step();
        p_din_valid = '0;
        step();
        checks++;
        if (p_dout_valid !== 1'b1 || p_dout !== model_b(16'h0F80) || p_dout_ch !== 1'b0) begin
            errors++; $display("FAIL cast_in_range: got valid=%b dout=%h ch=%0d, expected 1/%h/0", p_dout_valid, p_dout, p_dout_ch, model_b(16'h0F80));
        end
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (p_sat_flag !== 1'b0) begin errors++; $display("FAIL cast_flag_clear: got %b, expected 0", p_sat_flag); end
`endif
        step();
        checks++;
        if (p_dout_valid !== 1'b1 || p_dout !== model_b(16'h1080) || p_dout_ch !== 1'b1) begin
            errors++; $display("FAIL cast_saturate: got valid=%b dout=%h ch=%0d, expected 1/%h/1", p_dout_valid, p_dout, p_dout_ch, model_b(16'h1080));
        end
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (p_sat_flag !== 1'b1) begin errors++; $display("FAIL cast_flag_set: got %b, expected 1", p_sat_flag); end
`endif
        p_din       = {16'h0FFF, 16'h2000};
        p_din_valid = 2'b11;
        step();
        p_din_valid = '0;
        checks++;
        if (p_dout_valid !== 1'b0) begin errors++; $display("FAIL cast_gap: got valid=%b, expected 0", p_dout_valid); end
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (p_sat_count !== 16'h1) begin errors++; $display("FAIL cast_sat_count: got %h, expected 0001", p_sat_count); end
`endif
        step();
        checks++;
        if (p_dout !== model_b(16'h2000) || p_dout_ch !== 1'b0) begin
            errors++; $display("FAIL cast_sat_high: got dout=%h ch=%0d, expected %h/0", p_dout, p_dout_ch, model_b(16'h2000));
        end
        step();
        checks++;
        if (p_dout !== model_b(16'h0FFF) || p_dout_ch !== 1'b1) begin
            errors++; $display("FAIL cast_max_in_range: got dout=%h ch=%0d, expected %h/1", p_dout, p_dout_ch, model_b(16'h0FFF));
        end
        step();
`ifdef CAST_SAT_COUNT_EN
        checks++;
        if (p_sat_count !== 16'h2) begin errors++; $display("FAIL cast_sat_count2: got %h, expected 0002", p_sat_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_cast_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
